// File: rtl/product_bcd_converter.sv
// -----------------------------------------------------------------------------
// product_bcd_converter
//   Converts the unsigned product of the 4x4 multiplier into packed BCD for the
//   seven-segment display driver. It uses sequential double-dabble (shift-add-3)
//   and processes one input bit per clock. The result register is held stable
//   between conversions, so the display stage can sample it at any time.
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   rst   : synchronous, active-high reset (aborts a conversion, no done pulse)
//   start : conversion request, only looked at while idle
//   bin   : unsigned binary value to convert (captured on the accepted start)
//   busy  : high while a conversion is in progress
//   done  : one-cycle pulse, bcd has just been loaded with a new result
//   bcd   : packed BCD, [3:0]=ones, [7:4]=tens, [11:8]=hundreds
// -----------------------------------------------------------------------------
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Add 3 to each digit that is 5 or more. After the following left shift,
  // that digit then carries correctly into the next decade.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = s[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = s[4*d +: 4];
      end
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [BW-1:0]    scr_q,   scr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [BW-1:0]    bcd_q,   bcd_d;
  logic             done_q,  done_d;
  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    shifted_s;

  // Adjusted scratch shifted left, taking in the MSB of the remaining binary bits.
  always_comb begin
    adj_s     = add3(scr_q);
    shifted_s = {adj_s[BW-2:0], bin_q[WIDTH-1]};
  end

  // Next-state and datapath control for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          scr_d   = {BW{1'b0}};
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scr_d = shifted_s;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        // The last bit is being shifted in on this edge, so publish the result.
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted_s;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= {WIDTH{1'b0}};
      scr_q   <= {BW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      bcd_q   <= {BW{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
